icache_line_refill: RTL
=======================

Name: icache_line_refill

Overview:
- AHB-Lite master refill engine for the I-cache miss path.
- On a miss, issues one 4-beat 32-bit burst read for the missing 128-bit line and assembles the returned words into a line buffer.
- Delivers the completed line, with its base address, to the cache fill logic. The fill logic writes the tag and data arrays; the line then feeds the word-select path.
- Sits between the cache controller (upstream) and the AHB bus.

Parameters:
- CACHE_LINE, 128, line width in bits; fixed at 128 (4 words). Other values are unsupported.
- CACHE_SIZE, 8192, cache size in bytes. Used only to size the tag and index fields in line_addr decomposition checks.

Ports:
- HCLK  input  1  single clock.
- HRESETn  input  1  asynchronous, active-low reset.
- miss_req  input  1  refill request; held until miss_ack.
- miss_addr  input  32  faulting fetch address.
- miss_ack  output  1  1-cycle pulse when the request is accepted.
- busy  output  1  high from acceptance until the line is handed off.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type: IDLE=00, NONSEQ=10, SEQ=11.
- HBURST  output  3  INCR4 = 3'b011 (or WRAP4 = 3'b010, see Optional Feature).
- HSIZE  output  3  fixed 3'b010 (word).
- HWRITE  output  1  fixed 0.
- HREADY  input  1  AHB ready.
- HRDATA  input  32  AHB read data.
- HRESP  input  1  AHB response; 1 = ERROR.
- line_valid  output  1  completed line available.
- line_data  output  128  assembled line; word k occupies bits [32k+31:32k].
- line_addr  output  32  line base address ({miss_addr[31:4],4'b0}).
- line_err  output  1  qualifies line_valid; bus error during refill.
- fill_ready  input  1  consumer accepts the line when line_valid && fill_ready.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; HTRANS=IDLE; HADDR=0; HBURST=INCR4; miss_ack=0; busy=0; line_valid=0; line_err=0; line_data=0; line_addr=0; beat counters=0.
  - A reset mid-burst abandons the burst. No partial line is ever presented.
- States: IDLE, ADDR, DATA, HOLD, ABORT.
- IDLE:
  - If miss_req: latch line_addr; pulse miss_ack; set busy=1; go to ADDR.
  - One cycle from request to the first address phase.
- ADDR / DATA use pipelined AHB phases with independent 2-bit counters a_cnt (address beats issued) and d_cnt (data beats received).
  - Beat 0: HTRANS=NONSEQ, HADDR=line_addr + 4*a_cnt.
  - Beats 1-3: HTRANS=SEQ.
  - HADDR/HTRANS advance only on a cycle with HREADY=1.
  - After the 4th address is accepted, HTRANS=IDLE.
  - Each cycle with HREADY=1 and an outstanding data phase: write HRDATA into word slot d_cnt (beat order) and increment d_cnt.
  - When d_cnt wraps after beat 3, go to HOLD with line_valid=1.
  - Latency with zero wait states: 6 cycles from miss_ack to line_valid.
- HOLD:
  - line_valid, line_data, line_addr stay stable until fill_ready.
  - On the handshake cycle: next state IDLE; line_valid=0; busy=0.
  - miss_req in HOLD is not acknowledged until IDLE. There is no back-to-back bypass.
- Error (two-cycle AHB ERROR response):
  - On the first cycle with HRESP=1 and HREADY=0, drive HTRANS=IDLE for the next cycle and cancel the remaining beats.
  - Then go to ABORT. ABORT goes to HOLD with line_valid=1 and line_err=1.
  - line_data contents are undefined for an error line; the consumer must not install it.
- HREADY low stalls all counters and holds HADDR/HTRANS. Unbounded wait states are legal.
- HWRITE=0 and HSIZE=word at all times.

Optional Feature:
- Macro: ICACHE_REFILL_WRAP_EN.
- Defined: critical-word-first refill.
  - HBURST=WRAP4; first HADDR = {miss_addr[31:2],2'b00}; addresses wrap within the 16-byte line.
  - Data is written into slot (miss_addr[3:2] + d_cnt) mod 4, so line_data layout is identical to INCR4.
  - Adds output crit_valid (1-cycle pulse, beat 0 data) and crit_data[31:0] (holds the beat-0 word, reset 0).
- Undefined: INCR4 from the line base; no crit_* ports.

Test Plan:
- Zero-wait refill:
  - Stimulus: miss_addr=0x0000_0A14, HREADY=1, HRDATA=0x11,0x22,0x33,0x44.
  - Required: HADDR 0xA10, 0xA14, 0xA18, 0xA1C; HTRANS NONSEQ, SEQ, SEQ, SEQ; line_addr=0xA10; line_data=0x00000044_00000033_00000022_00000011; line_valid 6 cycles after miss_ack.
- Wait states:
  - Stimulus: HREADY low 2 cycles on beat 2 data.
  - Required: HADDR/HTRANS held; data slots correct; line_valid delayed by exactly 2 cycles.
- Backpressure:
  - Stimulus: fill_ready held 0 for 5 cycles, miss_req asserted meanwhile.
  - Required: line outputs stable; no miss_ack until the cycle after the handshake.
- Bus error:
  - Stimulus: ERROR response on beat 1.
  - Required: HTRANS=IDLE the next cycle; no further SEQ; line_valid=1 with line_err=1; returns to IDLE after fill_ready.
- Reset mid-burst:
  - Stimulus: HRESETn low after beat 2 address.
  - Required: HTRANS=IDLE, busy=0, line_valid=0 immediately; the next miss refills cleanly.
- With ICACHE_REFILL_WRAP_EN:
  - Stimulus: miss_addr=0xA18.
  - Required: HADDR 0xA18, 0xA1C, 0xA10, 0xA14; HBURST=010; crit_data = beat-0 word; line_data in address order.

Source files
------------

// File: rtl/icache_line_refill.sv
// AHB-Lite refill engine: one 4-beat word burst per I-cache miss, assembled into a 128-bit line.
// Define ICACHE_REFILL_WRAP_EN for critical-word-first WRAP4 refill with crit_valid/crit_data.
module icache_line_refill #(
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned CACHE_SIZE = 8192
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ack,
  output logic                  busy,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HRDATA,
  input  logic                  HRESP,
  output logic                  line_valid,
  output logic [CACHE_LINE-1:0] line_data,
  output logic [31:0]           line_addr,
  output logic                  line_err,
  input  logic                  fill_ready
`ifdef ICACHE_REFILL_WRAP_EN
  ,
  output logic                  crit_valid,
  output logic [31:0]           crit_data
`endif
);

  localparam int unsigned LineBytes = CACHE_LINE / 8;
  localparam int unsigned OffBits   = $clog2(LineBytes);
  localparam int unsigned IndexBits = $clog2(CACHE_SIZE / LineBytes);
  localparam int unsigned TagLo     = OffBits + IndexBits;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StHold,
    StAbort
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;
  logic [1:0]              a_cnt_q, a_cnt_d;
  logic [1:0]              d_cnt_q, d_cnt_d;
  logic                    dphase_q, dphase_d;
  logic                    busy_q, busy_d;
  logic                    line_valid_q, line_valid_d;
  logic                    line_err_q, line_err_d;
  logic [CACHE_LINE-1:0]   line_data_q, line_data_d;
  logic [31:0]             line_addr_q, line_addr_d;

  logic [1:0]              req_word;   // word index of the first beat for a new request
  logic [1:0]              crit_word;  // word index of beat 0 for the burst in flight
  logic [1:0]              next_word;
  logic [1:0]              d_slot;
  logic [31:0]             req_base;
  logic                    bus_err;
  logic                    unused_addr;

  assign unused_addr = ^miss_addr[3:0];

  // Line base rebuilt from its tag and index fields.
  assign req_base = {miss_addr[31:TagLo], miss_addr[TagLo-1:OffBits], {OffBits{1'b0}}};

  // First cycle of a two-cycle ERROR response is the one with HREADY low.
  assign bus_err = dphase_q && HRESP && !HREADY;

  assign next_word = crit_word + a_cnt_d;
  assign d_slot    = crit_word + d_cnt_q;

`ifdef ICACHE_REFILL_WRAP_EN
  logic [1:0]  crit_word_q, crit_word_d;
  logic        crit_valid_q, crit_valid_d;
  logic [31:0] crit_data_q, crit_data_d;

  assign req_word  = miss_addr[3:2];
  assign crit_word = crit_word_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      crit_word_q  <= 2'b00;
      crit_valid_q <= 1'b0;
      crit_data_q  <= 32'h0;
    end else begin
      crit_word_q  <= crit_word_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  always_comb begin
    crit_word_d  = crit_word_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    if (state_q == StIdle && miss_req) begin
      crit_word_d = req_word;
    end
    if ((state_q == StAddr) && HREADY && dphase_q && (d_cnt_q == 2'd0)) begin
      crit_valid_d = 1'b1;
      crit_data_d  = HRDATA;
    end
  end
`else
  assign req_word  = 2'b00;
  assign crit_word = 2'b00;
`endif

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req) state_d = StAddr;
      end
      StAddr: begin
        if (bus_err) state_d = StAbort;
        else if (HREADY && (a_cnt_q == 2'd3)) state_d = StData;
      end
      StData: begin
        if (bus_err) state_d = StAbort;
        else if (HREADY) state_d = StHold;
      end
      StAbort: begin
        if (HREADY) state_d = StHold;
      end
      StHold: begin
        if (fill_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q      <= 32'h0;
      htrans_q     <= HtransIdle;
      a_cnt_q      <= 2'd0;
      d_cnt_q      <= 2'd0;
      dphase_q     <= 1'b0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
      line_err_q   <= 1'b0;
      line_data_q  <= '0;
      line_addr_q  <= 32'h0;
    end else begin
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      a_cnt_q      <= a_cnt_d;
      d_cnt_q      <= d_cnt_d;
      dphase_q     <= dphase_d;
      busy_q       <= busy_d;
      line_valid_q <= line_valid_d;
      line_err_q   <= line_err_d;
      line_data_q  <= line_data_d;
      line_addr_q  <= line_addr_d;
    end
  end

  // Datapath next-state: address pipeline, data capture and line hand-off.
  always_comb begin
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    a_cnt_d      = a_cnt_q;
    d_cnt_d      = d_cnt_q;
    dphase_d     = dphase_q;
    busy_d       = busy_q;
    line_valid_d = line_valid_q;
    line_err_d   = line_err_q;
    line_data_d  = line_data_q;
    line_addr_d  = line_addr_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req) begin
          line_addr_d = req_base;
          haddr_d     = {req_base[31:4], req_word, 2'b00};
          htrans_d    = HtransNonseq;
          a_cnt_d     = 2'd0;
          d_cnt_d     = 2'd0;
          dphase_d    = 1'b0;
          busy_d      = 1'b1;
          line_err_d  = 1'b0;
        end
      end
      StAddr, StData: begin
        if (bus_err) begin
          htrans_d = HtransIdle;
          dphase_d = 1'b0;
        end else if (HREADY) begin
          if (dphase_q) begin
            line_data_d[{d_slot, 5'b00000} +: 32] = HRDATA;
            d_cnt_d = d_cnt_q + 2'd1;
          end
          if (state_q == StAddr) begin
            a_cnt_d  = a_cnt_q + 2'd1;
            dphase_d = 1'b1;
            if (a_cnt_q == 2'd3) begin
              htrans_d = HtransIdle;
            end else begin
              htrans_d = HtransSeq;
              haddr_d  = {line_addr_q[31:4], next_word, 2'b00};
            end
          end else begin
            // Only beat 3 is outstanding here; it completes the line.
            dphase_d     = 1'b0;
            line_valid_d = 1'b1;
          end
        end
      end
      StAbort: begin
        if (HREADY) begin
          line_valid_d = 1'b1;
          line_err_d   = 1'b1;
        end
      end
      StHold: begin
        if (fill_ready) begin
          line_valid_d = 1'b0;
          line_err_d   = 1'b0;
          busy_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    miss_ack   = (state_q == StIdle) && miss_req;
    busy       = busy_q;
    HADDR      = haddr_q;
    HTRANS     = htrans_q;
`ifdef ICACHE_REFILL_WRAP_EN
    HBURST     = 3'b010;
    crit_valid = crit_valid_q;
    crit_data  = crit_data_q;
`else
    HBURST     = 3'b011;
`endif
    HSIZE      = 3'b010;
    HWRITE     = 1'b0;
    line_valid = line_valid_q;
    line_data  = line_data_q;
    line_addr  = line_addr_q;
    line_err   = line_err_q;
  end

endmodule
